// File: rtl/tff_count_sequencer_if.sv
// Control-side bundle between the sequencing master and the T-flop counter sequencer.
interface tff_count_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int SW    = 8
);
  logic             start;
  logic             dir;
  logic [SW-1:0]    steps;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] t_vec;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output start, dir, steps, load, load_val, abort,
    input  count, t_vec, busy, done, wrap
  );

  modport slave (
    input  start, dir, steps, load, load_val, abort,
    output count, t_vec, busy, done, wrap
  );
endinterface

// File: rtl/tff_count_sequencer.sv
// Modulo-MOD up/down step counter built on a bank of T flip-flops.
// The sequencer only ever produces a toggle vector; the bank does the rest.

// Single T flip-flop of the bank.
module tff_bit (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);
  // toggle on t, clear on reset
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= q ^ t;
  end
endmodule

module tff_count_sequencer #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10,
  parameter int SW    = 8
) (
  input  logic clk,
  input  logic rst,
  tff_count_sequencer_if.slave bus
);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] count, count_next, t_vec;

  // T-flop bank, one instance per bit
  tff_bit u_bank [WIDTH-1:0] (
    .clk (clk),
    .rst (rst),
    .t   (t_vec),
    .q   (count)
  );

  // toggle only the bits that differ; held at zero while reset is asserted
  assign t_vec = rst ? '0 : (count ^ count_next);

  // state, step counter, latched direction and wrap pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  // next state and next count value
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    dir_d      = dir_q;
    wrap_d     = 1'b0;
    count_next = count;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          // out-of-range loads clamp to the top of the modulus
          count_next = ({1'b0, bus.load_val} >= MOD_W) ? TOP : bus.load_val;
        end else if (bus.start) begin
          dir_d   = bus.dir;
          rem_d   = bus.steps;
          state_d = (bus.steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          if (dir_q) begin
            count_next = (count == TOP) ? '0 : count + 1'b1;
            wrap_d     = (count == TOP);
          end else begin
            count_next = (count == '0) ? TOP : count - 1'b1;
            wrap_d     = (count == '0);
          end
          rem_d = rem_q - 1'b1;
          // last step lands together with done
          if (rem_q == SW'(1)) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.count = count;
  assign bus.t_vec = t_vec;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_tff_count_sequencer.sv
// Directed bench: expected per-cycle outputs are queued as stimulus is applied,
// then popped and compared one cycle at a time. A monitor checks the T-flop
// relation and modulus range on every cycle.
module tb_tff_count_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  tff_count_sequencer_if #(.WIDTH(4), .SW(8)) bus ();

  tff_count_sequencer #(.WIDTH(4), .MOD(10), .SW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] c;
    logic [3:0] tv;
    logic       b;
    logic       d;
    logic       w;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] c, input logic [3:0] tv,
                      input logic b, input logic d, input logic w);
    exp_t e;
    e.c = c; e.tv = tv; e.b = b; e.d = d; e.w = w;
    sb.push_back(e);
  endtask

  // one clock per queued entry, then compare everything visible after that edge
  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cyc();
      chk({tag, ".count"}, 32'(bus.count), 32'(e.c));
      chk({tag, ".t_vec"}, 32'(bus.t_vec), 32'(e.tv));
      chk({tag, ".busy"},  32'(bus.busy),  32'(e.b));
      chk({tag, ".done"},  32'(bus.done),  32'(e.d));
      chk({tag, ".wrap"},  32'(bus.wrap),  32'(e.w));
    end
  endtask

  // T-flop relation and range, every cycle
  logic [3:0] prev_c, prev_tv;
  logic       prev_rst;
  logic       armed = 1'b0;
  always @(posedge clk) begin
    prev_c   <= bus.count;
    prev_tv  <= bus.t_vec;
    prev_rst <= rst;
    armed    <= 1'b1;
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("mon.tff", 32'(bus.count), prev_rst ? 32'd0 : 32'(prev_c ^ prev_tv));
      chk("mon.range", 32'(bus.count < 4'd10), 32'd1);
    end
  end

  initial begin
    bus.start = 1'b1; bus.load = 1'b1; bus.load_val = 4'd5;
    bus.dir = 1'b1; bus.steps = 8'd3; bus.abort = 1'b0;

    // 1. reset dominates start/load
    rst = 1'b1;
    repeat (3) begin
      cyc();
      chk("rst.count", 32'(bus.count), 0);
      chk("rst.busy",  32'(bus.busy),  0);
      chk("rst.done",  32'(bus.done),  0);
      chk("rst.wrap",  32'(bus.wrap),  0);
      chk("rst.t_vec", 32'(bus.t_vec), 0);
    end
    rst = 1'b0; bus.start = 1'b0; bus.load = 1'b0;

    // 2. up across the wrap
    bus.load = 1'b1; bus.load_val = 4'd8;
    push(4'd8, 4'd0, 0, 0, 0);
    drain("up.load");
    bus.load = 1'b0; bus.start = 1'b1; bus.dir = 1'b1; bus.steps = 8'd4;
    cyc();
    bus.start = 1'b0;
    chk("up.k.count", 32'(bus.count), 8);
    chk("up.k.busy",  32'(bus.busy),  1);
    chk("up.k.t_vec", 32'(bus.t_vec), 1);
    push(4'd9, 4'b1001, 1, 0, 0);
    push(4'd0, 4'd1,    1, 0, 1);
    push(4'd1, 4'd3,    1, 0, 0);
    push(4'd2, 4'd0,    0, 1, 0);
    push(4'd2, 4'd0,    0, 0, 0);
    drain("up");

    // 3. down across the wrap
    bus.load = 1'b1; bus.load_val = 4'd1;
    push(4'd1, 4'd0, 0, 0, 0);
    drain("dn.load");
    bus.load = 1'b0; bus.start = 1'b1; bus.dir = 1'b0; bus.steps = 8'd3;
    cyc();
    bus.start = 1'b0;
    chk("dn.k.count", 32'(bus.count), 1);
    chk("dn.k.busy",  32'(bus.busy),  1);
    push(4'd0, 4'd9, 1, 0, 0);
    push(4'd9, 4'd1, 1, 0, 1);
    push(4'd8, 4'd0, 0, 1, 0);
    push(4'd8, 4'd0, 0, 0, 0);
    drain("dn");

    // 4. zero steps, clamp, load/start collision
    bus.start = 1'b1; bus.steps = 8'd0;
    cyc();
    bus.start = 1'b0;
    chk("zero.count", 32'(bus.count), 8);
    chk("zero.busy",  32'(bus.busy),  0);
    chk("zero.done",  32'(bus.done),  1);
    push(4'd8, 4'd0, 0, 0, 0);
    drain("zero.after");
    bus.load = 1'b1; bus.load_val = 4'd13;
    push(4'd9, 4'd0, 0, 0, 0);
    drain("clamp");
    bus.load_val = 4'd3; bus.start = 1'b1; bus.steps = 8'd5; bus.dir = 1'b1;
    push(4'd3, 4'd0, 0, 0, 0);
    drain("coll");
    bus.load = 1'b0; bus.start = 1'b0;
    push(4'd3, 4'd0, 0, 0, 0);
    drain("coll.idle");

    // 5a. abort after two steps
    bus.load = 1'b1; bus.load_val = 4'd0;
    push(4'd0, 4'd0, 0, 0, 0);
    drain("ab.load");
    bus.load = 1'b0; bus.start = 1'b1; bus.dir = 1'b1; bus.steps = 8'd6;
    cyc();
    bus.start = 1'b0;
    chk("ab.k.busy", 32'(bus.busy), 1);
    push(4'd1, 4'd3, 1, 0, 0);
    push(4'd2, 4'd1, 1, 0, 0);
    drain("ab");
    bus.abort = 1'b1;
    #1;
    chk("ab.t_vec", 32'(bus.t_vec), 0);
    cyc();
    bus.abort = 1'b0;
    chk("ab.count", 32'(bus.count), 2);
    chk("ab.busy",  32'(bus.busy),  0);
    chk("ab.done",  32'(bus.done),  0);
    push(4'd2, 4'd0, 0, 0, 0);
    push(4'd2, 4'd0, 0, 0, 0);
    drain("ab.after");

    // 5b. start during run is ignored
    bus.start = 1'b1; bus.steps = 8'd3;
    cyc();
    chk("ign.k.busy", 32'(bus.busy), 1);
    bus.steps = 8'd9;
    push(4'd3, 4'd7, 1, 0, 0);
    drain("ign.a");
    bus.start = 1'b0;
    push(4'd4, 4'd1, 1, 0, 0);
    push(4'd5, 4'd0, 0, 1, 0);
    push(4'd5, 4'd0, 0, 0, 0);
    drain("ign.b");

    // 6. reset mid-run
    bus.load = 1'b1; bus.load_val = 4'd0;
    push(4'd0, 4'd0, 0, 0, 0);
    drain("mr.load");
    bus.load = 1'b0; bus.start = 1'b1; bus.dir = 1'b1; bus.steps = 8'd10;
    cyc();
    bus.start = 1'b0;
    push(4'd1, 4'd3, 1, 0, 0);
    push(4'd2, 4'd1, 1, 0, 0);
    drain("mr.run");
    rst = 1'b1;
    push(4'd0, 4'd0, 0, 0, 0);
    drain("mr.rst");
    rst = 1'b0;
    push(4'd0, 4'd0, 0, 0, 0);
    push(4'd0, 4'd0, 0, 0, 0);
    drain("mr.idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
